// File: rtl/pc_sequencer_if.sv
// Fetch/decode bus for pc_sequencer: instruction-memory req/gnt/rvalid port,
// decode valid/ready port, execute-stage control-transfer inputs and status.
interface pc_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        is_branch;
  logic        is_jump;
  logic        take_branch;
  logic [31:0] target;
  logic        misaligned_trap;
  logic [63:0] instret;

  // Sequencer side.
  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc, misaligned_trap, instret,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, is_branch, is_jump,
    input  take_branch, target
  );

  // Memory / decode / execute side.
  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc, misaligned_trap, instret,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, is_branch, is_jump,
    output take_branch, target
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side sequencer: owns the PC, fetches one instruction at a time over a
// req/gnt/rvalid port, holds it for decode/execute until retired, then picks
// the next PC (sequential, branch/jump target, or trap vector on a misaligned
// target) and counts retired instructions.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0040_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0040_1000
) (
  input  logic            clock,
  input  logic            reset_n,
  pc_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  logic        retire;
  logic        redirect;
  logic        bad_target;
  logic [31:0] seq_pc;
  logic [31:0] next_pc;

  // The fetch address is the architectural PC; it only changes at retire,
  // so it is stable for the whole time imem_req is high.
  assign bus.imem_addr = pc;

  // Next-PC selection; control inputs only matter when retire is high.
  always_comb begin
    retire     = bus.inst_valid & bus.inst_ready;
    redirect   = bus.is_jump | (bus.is_branch & bus.take_branch);
    bad_target = redirect & (bus.target[1:0] != 2'b00);
    seq_pc     = bus.inst_pc + 32'd4;
    next_pc    = seq_pc;
    if (redirect) begin
      next_pc = bus.target;
    end
    if (bad_target) begin
      next_pc = TRAP_VECTOR;
    end
  end

  // Fetch/hold state machine with registered handshake and status outputs.
  // In REQ, imem_req is raised one cycle after entry from reset, so the first
  // request follows reset release by a cycle and gnt is only honoured while
  // the request is actually on the bus; entry from retire raises it at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state               <= ST_REQ;
      pc                  <= RESET_PC;
      bus.imem_req        <= 1'b0;
      bus.inst_valid      <= 1'b0;
      bus.inst            <= '0;
      bus.inst_pc         <= '0;
      bus.misaligned_trap <= 1'b0;
      bus.instret         <= '0;
    end else begin
      bus.misaligned_trap <= 1'b0;
      unique case (state)
        ST_REQ: begin
          if (!bus.imem_req) begin
            bus.imem_req <= 1'b1;
          end else if (bus.imem_gnt) begin
            bus.imem_req <= 1'b0;
            state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_rvalid) begin
            bus.inst       <= bus.imem_rdata;
            bus.inst_pc    <= pc;
            bus.inst_valid <= 1'b1;
            state          <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (retire) begin
            pc                  <= next_pc;
            bus.misaligned_trap <= bad_target;
            bus.instret         <= bus.instret + 64'd1;
            bus.inst_valid      <= 1'b0;
            bus.imem_req        <= 1'b1;
            state               <= ST_REQ;
          end
        end
        default: begin
          state <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, randomized
// fetch/retire traffic against a PC/instret reference model, and a reset
// asserted mid-fetch followed by stray read data.
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam logic [31:0] TRAP_PC = 32'h0040_1000;

  logic clock;
  logic reset_n;
  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC    (RST_PC),
    .TRAP_VECTOR (TRAP_PC)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int          total;
  int          bad;
  logic [31:0] m_pc;
  logic [63:0] m_instret;

  typedef struct {
    int          gd;
    int          vd;
    int          rd;
    logic [31:0] data;
    logic        br;
    logic        jmp;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] exp_addr;
    logic        exp_trap;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Architectural next-PC rule: {trap, next}.
  function automatic logic [32:0] model_next(input logic [31:0] cur, input logic br,
                                              input logic jmp, input logic tk,
                                              input logic [31:0] tgt);
    logic        taken;
    logic [31:0] seq;
    taken = (jmp === 1'b1) || ((br === 1'b1) && (tk === 1'b1));
    seq   = cur + 32'd4;
    if (!taken)            return {1'b0, seq};
    if (tgt % 4 != 0)      return {1'b1, TRAP_PC};
    return {1'b0, tgt};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_req"},     64'(bus.imem_req), 64'd0);
    check({tag, "_valid"},   64'(bus.inst_valid), 64'd0);
    check({tag, "_inst"},    64'(bus.inst), 64'd0);
    check({tag, "_inst_pc"}, 64'(bus.inst_pc), 64'd0);
    check({tag, "_trap"},    64'(bus.misaligned_trap), 64'd0);
    check({tag, "_instret"}, bus.instret, 64'd0);
    check({tag, "_addr"},    64'(bus.imem_addr), 64'(RST_PC));
  endtask

  // One full fetch/hold/retire transaction. Entry: at a negedge with the
  // request already on the bus. Exit: at the negedge after retire.
  task automatic do_instr(input int gd, input int vd, input int rd,
                          input logic [31:0] data, input logic br, input logic jmp,
                          input logic tk, input logic [31:0] tgt,
                          output logic [31:0] addr_after, output logic trap_after);
    logic [32:0] nx;
    check("req_issue", 64'(bus.imem_req), 64'd1);
    check("req_addr",  64'(bus.imem_addr), 64'(m_pc));
    for (int i = 0; i < gd; i++) begin
      bus.imem_gnt = 1'b0;
      @(negedge clock);
      check("req_hold", 64'({bus.imem_req, bus.imem_addr}), 64'({1'b1, m_pc}));
      check("trap_width", 64'(bus.misaligned_trap), 64'd0);
    end
    bus.imem_gnt = 1'b1;
    @(negedge clock);
    bus.imem_gnt = 1'b0;
    check("wait_req_low", 64'(bus.imem_req), 64'd0);
    check("trap_width", 64'(bus.misaligned_trap), 64'd0);
    for (int i = 0; i < vd; i++) begin
      bus.imem_gnt = 1'($urandom);
      @(negedge clock);
      check("wait_no_valid", 64'({bus.inst_valid, bus.imem_req}), 64'd0);
    end
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    @(negedge clock);
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    check("hold_valid", 64'(bus.inst_valid), 64'd1);
    check("hold_inst", 64'(bus.inst), 64'(data));
    check("hold_inst_pc", 64'(bus.inst_pc), 64'(m_pc));
    for (int i = 0; i < rd; i++) begin
      bus.inst_ready  = 1'b0;
      bus.is_branch   = 1'($urandom);
      bus.is_jump     = 1'($urandom);
      bus.take_branch = 1'($urandom);
      bus.target      = $urandom;
      bus.imem_rvalid = 1'($urandom);
      bus.imem_gnt    = 1'($urandom);
      @(negedge clock);
      check("hold_stable", 64'({bus.inst_valid, bus.inst, bus.inst_pc, bus.imem_req}),
            64'({1'b1, data, m_pc, 1'b0}));
      check("hold_instret", bus.instret, m_instret);
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.inst_ready  = 1'b1;
    bus.is_branch   = br;
    bus.is_jump     = jmp;
    bus.take_branch = tk;
    bus.target      = tgt;
    @(negedge clock);
    bus.inst_ready  = 1'b0;
    bus.is_branch   = 1'b0;
    bus.is_jump     = 1'b0;
    bus.take_branch = 1'b0;
    nx        = model_next(m_pc, br, jmp, tk, tgt);
    m_pc      = nx[31:0];
    m_instret = m_instret + 64'd1;
    check("retire_trap", 64'(bus.misaligned_trap), 64'(nx[32]));
    check("next_addr", 64'(bus.imem_addr), 64'(m_pc));
    check("next_req", 64'(bus.imem_req), 64'd1);
    check("retire_valid_low", 64'(bus.inst_valid), 64'd0);
    check("instret", bus.instret, m_instret);
    addr_after = bus.imem_addr;
    trap_after = bus.misaligned_trap;
  endtask

  initial begin
    logic [31:0] a;
    logic        t;
    logic [31:0] tgt;
    total = 0;
    bad   = 0;

    vecs[0] = '{0, 0, 0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0040_0004, 1'b0};
    vecs[1] = '{0, 0, 0, 32'h0000_0063, 1'b1, 1'b0, 1'b1, 32'h0040_0100, 32'h0040_0100, 1'b0};
    vecs[2] = '{0, 0, 0, 32'h0000_0063, 1'b1, 1'b0, 1'b0, 32'h0040_0200, 32'h0040_0104, 1'b0};
    vecs[3] = '{0, 0, 0, 32'h0000_006F, 1'b0, 1'b1, 1'bx, 32'h0040_0202, 32'h0040_1000, 1'b1};
    vecs[4] = '{5, 3, 4, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0040_1004, 1'b0};
    vecs[5] = '{1, 1, 1, 32'h0000_0033, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h0040_1008, 1'b0};
    vecs[6] = '{0, 2, 0, 32'h0000_006F, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    vecs[7] = '{0, 0, 0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h0000_0000, 1'b0};
    vecs[8] = '{2, 0, 0, 32'h0000_0063, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 32'h0040_1000, 1'b1};
    vecs[9] = '{0, 0, 2, 32'h0000_0067, 1'b0, 1'b1, 1'b0, 32'h0040_0000, 32'h0040_0000, 1'b0};

    reset_n         = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.inst_ready  = 1'b0;
    bus.is_branch   = 1'b0;
    bus.is_jump     = 1'b0;
    bus.take_branch = 1'b0;
    bus.target      = '0;
    repeat (2) @(negedge clock);
    check_reset_values("rst");
    reset_n = 1'b1;
    @(negedge clock);
    m_pc      = RST_PC;
    m_instret = '0;

    for (int i = 0; i < 10; i++) begin
      do_instr(vecs[i].gd, vecs[i].vd, vecs[i].rd, vecs[i].data, vecs[i].br,
               vecs[i].jmp, vecs[i].tk, vecs[i].tgt, a, t);
      check("tbl_addr", 64'(a), 64'(vecs[i].exp_addr));
      check("tbl_trap", 64'(t), 64'(vecs[i].exp_trap));
    end

    for (int i = 0; i < 40; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'($urandom),
               1'($urandom), tgt, a, t);
    end

    // Reset while waiting for read data, then stray rvalid across release.
    bus.imem_gnt = 1'b1;
    @(negedge clock);
    bus.imem_gnt = 1'b0;
    check("pre_rst_wait", 64'(bus.imem_req), 64'd0);
    #2 reset_n = 1'b0;
    #1 check_reset_values("async_rst");
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    bus.imem_rvalid = 1'b0;
    check("stray_valid", 64'(bus.inst_valid), 64'd0);
    check("stray_inst", 64'(bus.inst), 64'd0);
    check("restart_req", 64'(bus.imem_req), 64'd1);
    check("restart_addr", 64'(bus.imem_addr), 64'(RST_PC));
    m_pc      = RST_PC;
    m_instret = '0;
    do_instr(0, 0, 0, 32'h0000_0013, 1'b0, 1'b0, 1'b0, 32'h0, a, t);
    check("restart_next", 64'(a), 64'h0040_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
